ex_operand_pipe: RTL
====================

Name: ex_operand_pipe

Overview:
Parametrised ID->EX pipeline register for the RISC-V pipelined core. It holds the PC, source indices and source operand values for N source operands. While the stage is held, it snoops M writeback ports and overwrites stale operands in place. It adds several features: a valid/bubble bit, flush, bypass-at-load from writeback, per-operand forwarded flags and a saturating stall counter.

Parameters:
XLEN, 32, data and PC width
NSRC, 2, source operands per instruction (1..3)
NWB, 2, writeback snoop ports; port 0 has highest priority (youngest)
REGW, 5, register index width
SCNTW, 4, stall counter width
LOAD_BYPASS, 1, when 1, writeback data is also captured in the same cycle as load

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
load  in  1  advance: capture ID-side values
flush  in  1  kill EX contents, inserting a bubble
hold_fwd  in  1  stage held; snoop writeback
id_valid  in  1  ID instruction valid
id_pc  in  XLEN  ID PC
id_src_idx  in  NSRC*REGW  source register indices; operand k is at [k*REGW +: REGW]
id_src_data  in  NSRC*XLEN  register-file read data; operand k is at [k*XLEN +: XLEN]
wb_we  in  NWB  writeback enable per port
wb_rd  in  NWB*REGW  writeback destination index per port
wb_data  in  NWB*XLEN  writeback data per port
ex_valid  out  1  EX holds a live instruction
ex_pc  out  XLEN  registered PC
ex_src_idx  out  NSRC*REGW  registered indices
ex_src_data  out  NSRC*XLEN  registered operands
ex_fwd_hit  out  NSRC  operand k was overwritten from writeback since the last load
ex_stall_cnt  out  SCNTW  consecutive held cycles, saturating

Behaviour:
- Reset (reset=0, asynchronous) sets every output to 0: ex_valid, ex_pc, ex_src_idx, ex_src_data, ex_fwd_hit and ex_stall_cnt.
- Priority on each rising edge is flush > load > hold_fwd > idle.
- Flush:
  - ex_valid<=0, ex_fwd_hit<=0, ex_stall_cnt<=0.
  - PC, index and data registers are unchanged.
  - flush overrides a simultaneous load.
- Load:
  - ex_valid<=id_valid, ex_pc<=id_pc, ex_src_idx<=id_src_idx, ex_stall_cnt<=0.
  - For each operand k: ex_src_data[k]<=id_src_data[k] and ex_fwd_hit[k]<=0.
  - Exception when LOAD_BYPASS=1: if a writeback match exists on id_src_idx[k], take the winning wb_data instead and set ex_fwd_hit[k]<=1.
- Hold (hold_fwd=1 and load=0):
  - For each operand k, the match is computed against the registered ex_src_idx[k].
  - On a winning match: ex_src_data[k]<=wb_data[winner] and ex_fwd_hit[k]<=1.
  - Without a match, the operand and its flag hold.
  - ex_stall_cnt increments by 1 and saturates at 2^SCNTW-1.
- Idle (no flush, load or hold): all registers hold, and ex_stall_cnt holds.
- Match rule: port j matches index r iff wb_we[j] && wb_rd[j]==r && r!=0. The lowest matching j wins.
- Index 0 never matches, so x0 always keeps its loaded value.
- Forwarding on a bubble (ex_valid=0) still updates data; this is harmless and must not change ex_valid.
- Multiple operands may match the same or different ports in the same cycle; each operand resolves independently.
- Latency: one clock from input to output. There is no combinational path from inputs to outputs.
- Reset asserted mid-hold clears state immediately, without waiting for clk.

Decomposition:
- Shared package pipe_pkg holds:
  - localparam defaults XLEN=32, REGW=5;
  - typedef word_t = logic [XLEN-1:0];
  - typedef regidx_t = logic [REGW-1:0];
  - constant REG_ZERO = '0.
- One sub-module, wb_fwd_select: given one index plus the wb_we, wb_rd and wb_data vectors, it returns hit and data. It is priority-encoded and purely combinational.
  - The top instantiates it 2*NSRC times: NSRC on the ID-side indices (load bypass) and NSRC on the registered indices (hold).

Test Plan:
1. Reset: hold reset=0 with random inputs, then deassert -> all outputs 0. Assert reset mid-cycle -> outputs clear before the next edge.
2. Basic load: load=1, id_valid=1, id_pc=0x100, src0=x5/0xAAAA_0000, src1=x6/0x1234 -> next cycle ex_valid=1, ex_pc=0x100, data as loaded, ex_fwd_hit=00.
3. Hold forwarding: after scenario 2, hold_fwd=1 with wb_we=01, wb_rd[0]=6, wb_data[0]=0xBEEF -> src1=0xBEEF, src0 unchanged, ex_fwd_hit=10, ex_stall_cnt=1.
4. Priority and x0: hold with both ports writing rd=5 (port0 data 0x11, port1 data 0x22) -> src0=0x11. Then a load with src0=x0 and wb_rd=0, wb_we=11 -> src0 keeps the ID value and its hit stays 0.
5. Load bypass: LOAD_BYPASS=1, load with src0=x7/0x0 while wb_we[1]=1, wb_rd[1]=7, wb_data[1]=0x77 -> ex_src_data[0]=0x77, ex_fwd_hit[0]=1.
6. Flush vs load and saturation: flush=1 and load=1 together -> ex_valid=0, PC unchanged. Hold for 20 cycles with SCNTW=4 -> ex_stall_cnt=15. A subsequent load resets it to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the ID/EX stage.
package pipe_pkg;
    localparam int XLEN = 32;
    localparam int REGW = 5;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [REGW-1:0] regidx_t;

    // x0 is hardwired zero and must never be forwarded into.
    localparam regidx_t REG_ZERO = '0;
endpackage

// File: rtl/wb_fwd_select.sv
// Priority writeback selector: finds the youngest (lowest-numbered) writeback
// port targeting idx and returns its data. Purely combinational.
module wb_fwd_select #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int NWB  = 2
) (
    input  logic [REGW-1:0]     idx,
    input  logic [NWB-1:0]      wb_we,
    input  logic [NWB*REGW-1:0] wb_rd,
    input  logic [NWB*XLEN-1:0] wb_data,
    output logic                hit,
    output logic [XLEN-1:0]     data
);

    // Scan from the oldest port down so the lowest matching port wins last.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int j = NWB - 1; j >= 0; j--) begin
            if (wb_we[j] && (wb_rd[j*REGW +: REGW] == idx) &&
                (idx != REGW'(pipe_pkg::REG_ZERO))) begin
                hit  = 1'b1;
                data = wb_data[j*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/ex_operand_pipe.sv
// ID->EX operand register with flush, load-time bypass, in-place writeback
// snooping while held, per-operand forwarded flags and a stall counter.
module ex_operand_pipe #(
    parameter int XLEN        = pipe_pkg::XLEN,
    parameter int NSRC        = 2,
    parameter int NWB         = 2,
    parameter int REGW        = pipe_pkg::REGW,
    parameter int SCNTW       = 4,
    parameter bit LOAD_BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 flush,
    input  logic                 hold_fwd,
    input  logic                 id_valid,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [NSRC*REGW-1:0] id_src_idx,
    input  logic [NSRC*XLEN-1:0] id_src_data,
    input  logic [NWB-1:0]       wb_we,
    input  logic [NWB*REGW-1:0]  wb_rd,
    input  logic [NWB*XLEN-1:0]  wb_data,
    output logic                 ex_valid,
    output logic [XLEN-1:0]      ex_pc,
    output logic [NSRC*REGW-1:0] ex_src_idx,
    output logic [NSRC*XLEN-1:0] ex_src_data,
    output logic [NSRC-1:0]      ex_fwd_hit,
    output logic [SCNTW-1:0]     ex_stall_cnt
);

    logic [NSRC-1:0]           ld_hit;
    logic [NSRC-1:0][XLEN-1:0] ld_data;
    logic [NSRC-1:0]           hd_hit;
    logic [NSRC-1:0][XLEN-1:0] hd_data;

    // Instruction-level state: valid, PC, indices and the stall counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_src_idx   <= '0;
            ex_stall_cnt <= '0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_stall_cnt <= '0;
        end else if (load) begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_src_idx   <= id_src_idx;
            ex_stall_cnt <= '0;
        end else if (hold_fwd) begin
            if (ex_stall_cnt != {SCNTW{1'b1}})
                ex_stall_cnt <= ex_stall_cnt + SCNTW'(1);
        end
    end

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        // Bypass select on the incoming ID index.
        wb_fwd_select #(.XLEN(XLEN), .REGW(REGW), .NWB(NWB)) u_ld_sel (
            .idx     (id_src_idx[k*REGW +: REGW]),
            .wb_we   (wb_we),
            .wb_rd   (wb_rd),
            .wb_data (wb_data),
            .hit     (ld_hit[k]),
            .data    (ld_data[k])
        );

        // Snoop select on the already-registered index.
        wb_fwd_select #(.XLEN(XLEN), .REGW(REGW), .NWB(NWB)) u_hd_sel (
            .idx     (ex_src_idx[k*REGW +: REGW]),
            .wb_we   (wb_we),
            .wb_rd   (wb_rd),
            .wb_data (wb_data),
            .hit     (hd_hit[k]),
            .data    (hd_data[k])
        );

        // Operand k data and forwarded flag; flush only clears the flag.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                ex_src_data[k*XLEN +: XLEN] <= '0;
                ex_fwd_hit[k]               <= 1'b0;
            end else if (flush) begin
                ex_fwd_hit[k]               <= 1'b0;
            end else if (load) begin
                if (LOAD_BYPASS && ld_hit[k]) begin
                    ex_src_data[k*XLEN +: XLEN] <= ld_data[k];
                    ex_fwd_hit[k]               <= 1'b1;
                end else begin
                    ex_src_data[k*XLEN +: XLEN] <= id_src_data[k*XLEN +: XLEN];
                    ex_fwd_hit[k]               <= 1'b0;
                end
            end else if (hold_fwd && hd_hit[k]) begin
                ex_src_data[k*XLEN +: XLEN] <= hd_data[k];
                ex_fwd_hit[k]               <= 1'b1;
            end
        end
    end

endmodule
